uart_rx_sampler: RTL and testbench
==================================

Name: uart_rx_sampler

Overview:
- Synthesizable, parametrised UART receiver. It replaces fixed-period, 8-bit, no-parity serial sampling with a configurable one.
- Configurable items: half-bit period, data width, parity and stop bits. It also detects glitches, framing errors and break conditions.
- Received characters and error flags are pushed into an internal FIFO and drained through a valid/ready port.
- Sits on the SoC serial RX pin, in front of the bus-facing UART register block.

Parameters:
- DIV_W, 16, width of the cfg_half_period counter.
- DATA_BITS, 8, data bits per frame (5..9), LSB first.
- FIFO_DEPTH, 16, receive FIFO entries (power of two, >=2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx  input  1  serial line, idle high, asynchronous to clk
- cfg_half_period  input  DIV_W  clocks per half bit (53 at the simulation baud rate); value 0 is treated as 1
- cfg_parity_en  input  1  a parity bit follows the data bits
- cfg_parity_odd  input  1  1 = odd parity, 0 = even parity
- cfg_two_stop  input  1  two stop bits are sampled
- out_valid  output  1  FIFO head entry is valid
- out_ready  input  1  consumer accepts the head entry
- out_data  output  DATA_BITS  head entry data
- out_parity_err  output  1  head entry parity mismatch
- out_frame_err  output  1  head entry had a stop bit sampled low
- out_break  output  1  head entry: all data bits 0 and first stop bit 0
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of stored entries
- overflow  output  1  sticky flag: a frame was dropped because the FIFO was full
- clr_overflow  input  1  clears overflow
- busy  output  1  FSM is not in IDLE

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; rx synchroniser preset to 1.
- rx passes through a 2-flop synchroniser. An edge detector on the synchronised value flags a 1->0 transition.
- Config latch: cfg_* are latched on start detection. Changes mid-frame take effect on the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: a falling edge loads the counter with H = max(cfg_half_period, 1) and moves to START.
- Counter: counts down each clk. A sample occurs on the cycle it reaches 1. The counter reloads with 2H for every subsequent bit.
- START: sample = 1 -> glitch; return to IDLE, nothing pushed. Sample = 0 -> DATA, bit index 0.
- DATA: each sample shifts into the shift register LSB first. After DATA_BITS samples, go to PARITY if parity is enabled, else STOP1.
- PARITY: computed parity = XOR(data) XOR cfg_parity_odd. parity_err = sample != computed parity.
- STOP1: sample 0 -> frame_err = 1; break = frame_err && data == 0.
  - If cfg_two_stop, go to STOP2, where a 0 sample also sets frame_err.
  - Otherwise push and go to IDLE.
- Push timing: the entry {break, frame_err, parity_err, data} is written on the clock edge following the final stop sample. out_valid rises one cycle later if the FIFO was empty.
- IDLE edge detection is re-enabled in the cycle after the final stop sample. Back-to-back frames are received with no gap.
- Break handling: after a break, the FSM waits in IDLE for rx to read 1 before arming a new start detection. A held-low line yields exactly one break entry.
- FIFO read: the head entry is presented combinationally from storage. A pop occurs when out_valid && out_ready. Pointers wrap modulo FIFO_DEPTH.
- Full FIFO: a push with no simultaneous pop drops the entry and sets overflow.
  - A simultaneous push and pop when full is accepted; level is unchanged.
  - A push and pop when empty is a push only.
- overflow: set and clr_overflow in the same cycle leaves overflow = 1 (set wins).
- Reset mid-frame: FSM goes to IDLE, the FIFO is emptied, overflow is cleared, and no partial entry is written.

Decomposition:
- Shared package uart_pkg holds the FSM state enum, an entry struct/width constant (DATA_BITS+3), and the parity-mode encoding.
- One sub-module: uart_rx_fifo (parametrised synchronous FIFO with level, full/empty, push/pop, and drop-on-full reporting).
- The FSM, counter and synchroniser stay in uart_rx_sampler.

Test Plan:
- 8N1 frame for 0x41, H=53 -> one entry: data 0x41, all flags 0, out_valid about 1 synchroniser delay + 9.5 bits + 2 cycles after the start edge.
- Even parity enabled, 0x07 sent with parity bit 0 -> data 0x07, parity_err = 1. Same frame with parity bit 1 -> parity_err = 0.
- 20-cycle low glitch on an idle line, H=53 -> no entry, busy falls within 56 cycles.
- Line held low for 3 frame times, then released -> exactly one entry: data 0x00, frame_err = 1, break = 1.
- FIFO_DEPTH=4, out_ready=0, 5 frames (0x10..0x14) -> level 4, overflow = 1, drained order 0x10..0x13.
  - Next: pulse clr_overflow -> overflow = 0.
- reset asserted mid DATA of 0x55, then 0xAA sent -> only 0xAA is received, level 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART receive sampler: FSM states, parity mode and
// the flag portion of a FIFO entry.
package uart_pkg;

  // state  | meaning
  // IDLE   | line idle, waiting for a falling edge
  // START  | half-bit wait, then confirm start bit is still low
  // DATA   | sampling data bits, LSB first
  // PARITY | sampling the parity bit
  // STOP1  | sampling the first stop bit
  // STOP2  | sampling the second stop bit
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_e;

  // Upper bits of every FIFO entry; data bits sit below these.
  typedef struct packed {
    logic brk;
    logic frame_err;
    logic parity_err;
  } entry_flags_t;

  localparam int FLAG_W = $bits(entry_flags_t);

  function automatic int entry_width(input int data_bits);
    return data_bits + FLAG_W;
  endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Receive-side valid/ready port carrying one character plus its error flags.
interface uart_rx_sampler_if #(
  parameter int DATA_BITS = 8
);
  logic                 valid;
  logic                 ready;
  logic [DATA_BITS-1:0] data;
  logic                 parity_err;
  logic                 frame_err;
  logic                 brk;

  modport master (output valid, data, parity_err, frame_err, brk, input ready);
  modport slave  (input valid, data, parity_err, frame_err, brk, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received entries. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is
// dropped and reported on 'dropped' for one cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   dropped
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dropped = push && !do_push;
  assign head    = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_sampler.sv
// Configurable UART receiver: synchroniser, start detection, half-bit
// down-counter, frame FSM and receive FIFO with sticky overflow.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx,
  input  logic [DIV_W-1:0]            cfg_half_period,
  input  logic                        cfg_parity_en,
  input  logic                        cfg_parity_odd,
  input  logic                        cfg_two_stop,
  uart_rx_sampler_if.master           out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        clr_overflow,
  output logic                        busy
);
  localparam int CNT_W   = DIV_W + 1;
  localparam int IDX_W   = $clog2(DATA_BITS);
  localparam int ENTRY_W = entry_width(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic rx_meta, rx_sync, rx_prev, fall;
  rx_state_e state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 tick, start, push;
  logic [DIV_W-1:0]     half_eff, half_q;
  logic                 par_en_q, two_stop_q;
  parity_mode_e         par_mode_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 perr_q, ferr_q, brk_q, wait_high_q;
  logic                 parity_calc, stop_low, ferr_now, brk_now;
  entry_flags_t         flags_now, head_flags;
  logic                 push_q;
  logic [ENTRY_W-1:0]   entry_q, head;
  logic                 empty, dropped;

  assign half_eff    = (cfg_half_period == '0) ? DIV_W'(1) : cfg_half_period;
  assign fall        = rx_prev & ~rx_sync;
  assign tick        = (cnt == CNT_W'(1));
  assign parity_calc = (^shift_q) ^ (par_mode_q == PAR_ODD);
  assign stop_low    = ~rx_sync;
  // ferr_q is cleared at start, so in STOP1 this is just the current sample.
  assign ferr_now    = ferr_q | stop_low;
  assign brk_now     = (state == STOP1) ? (stop_low && shift_q == '0) : brk_q;
  assign flags_now   = {brk_now, ferr_now, perr_q};
  assign busy        = (state != IDLE);

  // Two-flop synchroniser plus one more flop for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) {rx_meta, rx_sync, rx_prev} <= 3'b111;
    else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; push fires on the final stop sample.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: if (fall && !wait_high_q) begin
        start     = 1'b1;
        state_nxt = START;
      end
      START:  if (tick) state_nxt = rx_sync ? IDLE : DATA;
      DATA:   if (tick && bit_idx_q == LAST_IDX) state_nxt = par_en_q ? PARITY : STOP1;
      PARITY: if (tick) state_nxt = STOP1;
      STOP1: if (tick) begin
        if (two_stop_q) state_nxt = STOP2;
        else begin
          state_nxt = IDLE;
          push      = 1'b1;
        end
      end
      STOP2: if (tick) begin
        state_nxt = IDLE;
        push      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timer, config latch, shift register, error capture and entry staging.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      half_q      <= '0;
      par_en_q    <= 1'b0;
      par_mode_q  <= PAR_EVEN;
      two_stop_q  <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      brk_q       <= 1'b0;
      wait_high_q <= 1'b0;
      push_q      <= 1'b0;
      entry_q     <= '0;
    end else begin
      push_q <= push;
      if (push) entry_q <= {flags_now, shift_q};
      // After a break, hold off start detection until the line returns high.
      if (push && brk_now) wait_high_q <= 1'b1;
      else if (rx_sync)    wait_high_q <= 1'b0;
      if (start) begin
        cnt        <= {1'b0, half_eff};
        half_q     <= half_eff;
        par_en_q   <= cfg_parity_en;
        par_mode_q <= parity_mode_e'(cfg_parity_odd);
        two_stop_q <= cfg_two_stop;
        bit_idx_q  <= '0;
        perr_q     <= 1'b0;
        ferr_q     <= 1'b0;
        brk_q      <= 1'b0;
      end else if (state != IDLE) begin
        cnt <= tick ? {half_q, 1'b0} : cnt - CNT_W'(1);
        if (tick) begin
          case (state)
            DATA: begin
              shift_q   <= {rx_sync, shift_q[DATA_BITS-1:1]};
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
            PARITY: perr_q <= (rx_sync != parity_calc);
            STOP1: begin
              ferr_q <= stop_low;
              brk_q  <= brk_now;
            end
            STOP2:   ferr_q <= ferr_now;
            default: ;
          endcase
        end
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             overflow <= 1'b0;
    else if (dropped)      overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_q),
    .push_data (entry_q),
    .pop       (out.ready && out.valid),
    .head      (head),
    .empty     (empty),
    .level     (fifo_level),
    .dropped   (dropped)
  );

  assign head_flags     = entry_flags_t'(head[ENTRY_W-1:DATA_BITS]);
  assign out.valid      = !empty;
  assign out.data       = head[DATA_BITS-1:0];
  assign out.parity_err = head_flags.parity_err;
  assign out.frame_err  = head_flags.frame_err;
  assign out.brk        = head_flags.brk;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: serial frames are driven bit by bit and the
// drained FIFO entries are compared with a frame-level model.
module tb_uart_rx_sampler;
  localparam int DIV_W      = 16;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             rx = 1'b1;
  logic [DIV_W-1:0] cfg_half_period = 16'd53;
  logic             cfg_parity_en = 1'b0;
  logic             cfg_parity_odd = 1'b0;
  logic             cfg_two_stop = 1'b0;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic             clr_overflow = 1'b0;
  logic             busy;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  uart_rx_sampler_if #(.DATA_BITS(DATA_BITS)) out_bus ();

  uart_rx_sampler #(
    .DIV_W      (DIV_W),
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rx              (rx),
    .cfg_half_period (cfg_half_period),
    .cfg_parity_en   (cfg_parity_en),
    .cfg_parity_odd  (cfg_parity_odd),
    .cfg_two_stop    (cfg_two_stop),
    .out             (out_bus),
    .fifo_level      (fifo_level),
    .overflow        (overflow),
    .clr_overflow    (clr_overflow),
    .busy            (busy)
  );

  // Frame-level reference: what a receiver must report for the bits sent.
  function automatic exp_t model(input logic [7:0] d, input bit pen, input bit pod,
                                 input bit pbit, input bit two, input bit s1, input bit s2);
    exp_t e;
    e.data = d;
    e.perr = pen && ((($countones(d) + int'(pbit) + int'(pod)) % 2) == 1);
    e.ferr = !s1 || (two && !s2);
    e.brk  = (d == 8'h00) && !s1;
    return e;
  endfunction

  task automatic model_push(input exp_t e);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic b, input int h);
    rx = b;
    repeat (2 * h) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int h, input bit pen, input bit pod,
                            input bit pbit, input bit two, input bit s1, input bit s2,
                            input bit scramble);
    cfg_half_period = h[DIV_W-1:0];
    cfg_parity_en   = pen;
    cfg_parity_odd  = pod;
    cfg_two_stop    = two;
    drive_bit(1'b0, h);
    if (scramble) begin
      cfg_half_period = DIV_W'($urandom_range(0, 40));
      cfg_parity_en   = 1'($urandom);
      cfg_parity_odd  = 1'($urandom);
      cfg_two_stop    = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) drive_bit(d[i], h);
    if (pen) drive_bit(pbit, h);
    drive_bit(s1, h);
    if (two) drive_bit(s2, h);
    rx = 1'b1;
  endtask

  task automatic pop_entry(output exp_t got, output bit seen);
    int n = 0;
    @(negedge clk);
    while (out_bus.valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    seen = (out_bus.valid === 1'b1);
    got  = {out_bus.data, out_bus.parity_err, out_bus.frame_err, out_bus.brk};
    out_bus.ready = seen;
    @(posedge clk);
    #1;
    out_bus.ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_bus.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_bus.valid); end
    vectors++;
    if (fifo_level !== '0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    vectors++;
    if (overflow !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags: overflow %b busy %b want 0 0", overflow, busy);
    end
    vectors++;
    if ({out_bus.data, out_bus.parity_err, out_bus.frame_err, out_bus.brk} !== 11'h0) begin
      miscompares++; $display("FAIL reset_head: got %h want 0", {out_bus.data, out_bus.parity_err, out_bus.frame_err, out_bus.brk});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || out_bus.valid !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_idle: busy %b valid %b want 0 0", busy, out_bus.valid);
    end
  endtask

  task automatic test_8n1();
    int   n = 0;
    exp_t got, e;
    bit   seen;
    fork
      send_frame(8'h41, 53, 0, 0, 0, 0, 1, 1, 0);
      begin
        while (out_bus.valid !== 1'b1 && n < 3000) begin
          @(posedge clk);
          #1;
          n++;
        end
      end
    join
    // 2 sync cycles + 9.5 bits of 106 cycles + 2 cycles = 1011
    vectors++;
    if (n < 1005 || n > 1017) begin miscompares++; $display("FAIL 8n1_latency: got %0d cycles want 1005..1017", n); end
    vectors++;
    if (fifo_level !== LVL_W'(1)) begin miscompares++; $display("FAIL 8n1_level: got %0d want 1", fifo_level); end
    model_push(model(8'h41, 0, 0, 0, 0, 1, 1));
    e = exp_q.pop_front();
    pop_entry(got, seen);
    vectors++;
    if (!seen || got !== e) begin miscompares++; $display("FAIL 8n1_entry: got %h seen %b want %h", got, seen, e); end
    @(negedge clk);
    vectors++;
    if (out_bus.valid !== 1'b0) begin miscompares++; $display("FAIL 8n1_drained: valid %b want 0", out_bus.valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_parity();
    exp_t got, e;
    bit   seen;
    send_frame(8'h07, 20, 1, 0, 0, 0, 1, 1, 0);
    model_push(model(8'h07, 1, 0, 0, 0, 1, 1));
    send_frame(8'h07, 20, 1, 0, 1, 0, 1, 1, 0);
    model_push(model(8'h07, 1, 0, 1, 0, 1, 1));
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      pop_entry(got, seen);
      vectors++;
      if (!seen || got !== e) begin miscompares++; $display("FAIL parity_entry%0d: got %h want %h", i, got, e); end
    end
  endtask

  task automatic test_glitch();
    bit saw_busy = 0;
    int fell_at = 0;
    cfg_half_period = 16'd53;
    cfg_parity_en = 0;
    cfg_two_stop = 0;
    rx = 1'b0;
    for (int n = 1; n <= 80 && fell_at == 0; n++) begin
      @(posedge clk);
      #1;
      if (n == 20) rx = 1'b1;
      if (busy === 1'b1) saw_busy = 1;
      else if (saw_busy) fell_at = n;
    end
    vectors++;
    if (!saw_busy) begin miscompares++; $display("FAIL glitch_busy_rise: busy never rose"); end
    vectors++;
    if (fell_at == 0 || fell_at > 56) begin miscompares++; $display("FAIL glitch_busy_fall: fell at %0d want 1..56", fell_at); end
    repeat (200) @(posedge clk);
    #1;
    vectors++;
    if (fifo_level !== '0 || out_bus.valid !== 1'b0) begin
      miscompares++; $display("FAIL glitch_no_entry: level %0d valid %b want 0 0", fifo_level, out_bus.valid);
    end
  endtask

  task automatic test_break();
    exp_t got, e;
    bit   seen;
    cfg_half_period = 16'd10;
    cfg_parity_en = 0;
    cfg_two_stop = 0;
    rx = 1'b0;
    repeat (600) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    vectors++;
    if (fifo_level !== LVL_W'(1)) begin miscompares++; $display("FAIL break_level: got %0d want 1", fifo_level); end
    model_push(model(8'h00, 0, 0, 0, 0, 0, 0));
    e = exp_q.pop_front();
    pop_entry(got, seen);
    vectors++;
    if (!seen || got !== e) begin miscompares++; $display("FAIL break_entry: got %h want %h", got, e); end
    @(negedge clk);
    vectors++;
    if (out_bus.valid !== 1'b0) begin miscompares++; $display("FAIL break_single: valid %b want 0", out_bus.valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    exp_t got, e;
    bit   seen;
    out_bus.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h10 + 8'(i), 10, 0, 0, 0, 0, 1, 1, 0);
      model_push(model(8'h10 + 8'(i), 0, 0, 0, 0, 1, 1));
    end
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (fifo_level !== LVL_W'(FIFO_DEPTH)) begin miscompares++; $display("FAIL ovf_level: got %0d want %0d", fifo_level, FIFO_DEPTH); end
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      e = exp_q.pop_front();
      pop_entry(got, seen);
      vectors++;
      if (!seen || got !== e) begin miscompares++; $display("FAIL ovf_order%0d: got %h want %h", i, got, e); end
    end
    vectors++;
    if (overflow !== 1'b1 || fifo_level !== '0) begin
      miscompares++; $display("FAIL ovf_sticky: overflow %b level %0d want 1 0", overflow, fifo_level);
    end
    clr_overflow = 1'b1;
    @(posedge clk);
    #1;
    clr_overflow = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_reset_midframe();
    exp_t got, e;
    bit   seen;
    for (int i = 0; i < 5; i++) send_frame(8'h20 + 8'(i), 10, 0, 0, 0, 0, 1, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (fifo_level !== LVL_W'(FIFO_DEPTH) || overflow !== 1'b1) begin
      miscompares++; $display("FAIL rst_prefill: level %0d overflow %b want %0d 1", fifo_level, overflow, FIFO_DEPTH);
    end
    drive_bit(1'b0, 10);
    drive_bit(1'b1, 10);
    drive_bit(1'b0, 10);
    drive_bit(1'b1, 10);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_busy_mid: got %b want 1", busy); end
    reset = 1'b1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (fifo_level !== '0 || overflow !== 1'b0 || busy !== 1'b0 || out_bus.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_clear: level %0d overflow %b busy %b valid %b want 0 0 0 0", fifo_level, overflow, busy, out_bus.valid);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    repeat (30) @(posedge clk);
    #1;
    send_frame(8'hAA, 10, 0, 0, 0, 0, 1, 1, 0);
    model_push(model(8'hAA, 0, 0, 0, 0, 1, 1));
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (fifo_level !== LVL_W'(1)) begin miscompares++; $display("FAIL rst_after_level: got %0d want 1", fifo_level); end
    e = exp_q.pop_front();
    pop_entry(got, seen);
    vectors++;
    if (!seen || got !== e) begin miscompares++; $display("FAIL rst_after_entry: got %h want %h", got, e); end
  endtask

  task automatic test_random();
    exp_t got, e;
    bit   seen;
    for (int b = 0; b < 3; b++) begin
      int nf = $urandom_range(2, 4);
      for (int f = 0; f < nf; f++) begin
        int         h    = $urandom_range(3, 12);
        bit         pen  = 1'($urandom);
        bit         pod  = 1'($urandom);
        bit         pbit = 1'($urandom);
        bit         two  = 1'($urandom);
        bit         s1   = ($urandom_range(0, 3) != 0);
        bit         s2   = ($urandom_range(0, 3) != 0);
        logic [7:0] d    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        send_frame(d, h, pen, pod, pbit, two, s1, s2, 1);
        model_push(model(d, pen, pod, pbit, two, s1, s2));
        // A low final stop bit leaves no falling edge for the next start.
        if ((two ? s2 : s1) == 1'b0) drive_bit(1'b1, h);
      end
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (fifo_level !== LVL_W'(exp_q.size()) || overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_level%0d: level %0d overflow %b want %0d 0", b, fifo_level, overflow, exp_q.size());
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        pop_entry(got, seen);
        vectors++;
        if (!seen || got !== e) begin miscompares++; $display("FAIL rand_entry%0d: got %h want %h", b, got, e); end
      end
    end
  endtask

  initial begin
    out_bus.ready = 1'b0;
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_break();
    test_overflow();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
